// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and issues in-order imem requests.
// Returned words are buffered with their PC and handed to decode over valid/ready.
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] rsp_pc, rsp_pc_n;
  logic [CW-1:0]   outstanding, outstanding_n;
  logic [CW-1:0]   drop_cnt, drop_cnt_n;
  logic [CW-1:0]   count, count_n;
  logic [PW-1:0]   rd_ptr, rd_ptr_n;
  logic [PW-1:0]   wr_ptr, wr_ptr_n;
  logic            wr_en;
  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_q    [FIFO_DEPTH];

  logic [CW:0]     inflight;
  logic            credit, req_fire, pop, push, drop;
  logic [XLEN-1:0] redirect_aligned;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};

  // In-flight requests plus buffered words must never exceed the buffer size
  assign inflight       = (CW+1)'(outstanding) + (CW+1)'(count);
  assign credit         = inflight < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = ~rst & ~redirect_valid & credit;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign if_valid = ~rst & (count != '0);
  assign if_instr = instr_q[rd_ptr];
  assign if_pc    = pc_q[rd_ptr];
  assign pop      = if_valid & if_ready;
  assign drop     = imem_rsp_valid & (drop_cnt != '0);
  assign push     = imem_rsp_valid & (drop_cnt == '0);

  // Next-state: redirect wins over every other update this cycle
  always_comb begin
    fetch_pc_n    = fetch_pc;
    rsp_pc_n      = rsp_pc;
    outstanding_n = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_n    = drop_cnt;
    count_n       = count;
    rd_ptr_n      = rd_ptr;
    wr_ptr_n      = wr_ptr;
    wr_en         = 1'b0;
    if (redirect_valid) begin
      fetch_pc_n = redirect_aligned;
      rsp_pc_n   = redirect_aligned;
      drop_cnt_n = outstanding - CW'(imem_rsp_valid);
      count_n    = '0;
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
    end else begin
      if (req_fire) fetch_pc_n = fetch_pc + XLEN'(4);
      if (drop)     drop_cnt_n = drop_cnt - CW'(1);
      if (push) begin
        wr_en    = 1'b1;
        rsp_pc_n = rsp_pc + XLEN'(4);
        wr_ptr_n = wr_ptr + PW'(1);
      end
      if (pop) rd_ptr_n = rd_ptr + PW'(1);
      count_n = count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_VECTOR;
      rsp_pc      <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      rsp_pc      <= rsp_pc_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;
      count       <= count_n;
      rd_ptr      <= rd_ptr_n;
      wr_ptr      <= wr_ptr_n;
    end
  end

  // Buffer storage needs no reset; count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_q[wr_ptr] <= imem_rsp_data;
      pc_q[wr_ptr]    <= rsp_pc;
    end
  end

  // A response with nothing outstanding means the memory broke protocol
  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rsp_valid && (outstanding == '0)));
  end

endmodule
